pio_edge_servicer: RTL and testbench
====================================

Name: pio_edge_servicer

Overview:
- Avalon-MM initiator that services the 6-bit edge-capture input PIO (`niosHello_pio_1` class slave) in hardware, without the Nios CPU.
- Programs the PIO interrupt mask, waits for `irq`, then reads and clears the edge-capture register and snapshots the input levels.
- Delivers each serviced batch as one event on a valid/ready stream toward fabric logic.
- Sits between the PIO `s1` slave and a downstream event consumer.

Parameters:
- WIDTH, 6, PIO data width; bits used from `readdata`/`writedata`.
- MASK_INIT, 6'h3F, mask written to PIO address 2 after reset.
- TS_W, 32, timestamp width; used only when the optional feature is enabled.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avm_address  out  2  PIO register address (0=data, 2=mask, 3=edge_capture)
- avm_chipselect  out  1  PIO select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  32  write data, zero-extended above WIDTH
- avm_readdata  in  32  PIO readdata; registered in the slave, valid 1 cycle after the address is presented
- pio_irq  in  1  PIO interrupt, `|(edge_capture & irq_mask)`
- cfg_mask  in  WIDTH  new mask value from control logic
- cfg_mask_wr  in  1  one-cycle pulse: request a mask reprogram
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts the event
- ev_edges  out  WIDTH  captured edge bits (masked)
- ev_level  out  WIDTH  input levels sampled after the clear
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (sync, high):
  - FSM goes to INIT.
  - `avm_chipselect`=0, `avm_write_n`=1, `avm_address`=0, `avm_writedata`=0.
  - `ev_valid`=0, `ev_edges`=0, `ev_level`=0, `busy`=1.
  - Mask shadow register = MASK_INIT.
- Reset mid-transaction aborts immediately. Any partially read edges are discarded; the PIO keeps its own state.
- FSM states:
  - INIT: write address 2 with the mask shadow (1 cycle) -> IDLE.
  - IDLE: `cfg_mask_wr` (pending flag) has priority -> latch `cfg_mask` into the shadow -> INIT. Else `pio_irq`=1 -> RD_CAP. `busy`=0 only here.
  - RD_CAP: chipselect=1, write_n=1, address=3 -> RD_CAP_W.
  - RD_CAP_W: same drive; sample `avm_readdata[WIDTH-1:0] & shadow` into the edge register -> CLR.
  - CLR: write address 3, writedata=all ones (1 cycle). The slave clears all capture bits on any write -> RD_LVL.
  - RD_LVL: read address 0 -> RD_LVL_W.
  - RD_LVL_W: sample level. If the edge register == 0 (spurious or mask changed) -> IDLE with no event. Else -> EMIT.
  - EMIT: `ev_valid`=1; `ev_edges`/`ev_level` held stable until `ev_valid && ev_ready` -> IDLE.
- Bus outputs are registered. chipselect is high only in INIT, RD_CAP, RD_CAP_W, CLR, RD_LVL, RD_LVL_W.
- Latency: `irq` rise to `ev_valid` = 6 cycles (IDLE detect + 5 states).
- Back-pressure: while in EMIT, new edges keep accumulating in the PIO and coalesce into the next event; none are lost.
- Edges arriving between RD_CAP_W and CLR are lost. This window is 1 cycle and is documented as a PIO limitation.
- `cfg_mask_wr` arriving outside IDLE sets the pending flag with the latest value; it is serviced at the next IDLE.
- `pio_irq` still high when returning to IDLE means a new service pass starts the next cycle.

Optional Feature:
- Macro: PIO_EVT_TIMESTAMP_EN.
- Enabled:
  - Adds a free-running TS_W counter (reset 0, wraps) and output port `ev_ts` (TS_W).
  - `ev_ts` is latched with the counter value in RD_CAP_W and held through EMIT.
- Disabled: no counter, no `ev_ts` port. All other behaviour is identical.

Decomposition:
- Package `pio_evt_pkg`:
  - FSM state enum.
  - PIO address constants: ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
  - Default WIDTH.
- Sub-module `pio_evt_timestamp`: counter plus capture register, instantiated only under PIO_EVT_TIMESTAMP_EN.
- Everything else stays flat.

Test Plan:
- Reset release -> one write to address 2 with data 0x3F on the 1st cycle after reset; `busy` falls the next cycle.
- PIO model edge_capture=0x05, level=0x04, irq rises -> read addr 3, write addr 3 data 0xFFFFFFFF, read addr 0. Then `ev_valid` with `ev_edges`=0x05, `ev_level`=0x04, exactly 6 cycles after irq.
- Hold `ev_ready`=0 for 20 cycles while bit 1 toggles in the PIO -> event 1 stays stable. After accept, a second event arrives with `ev_edges`=0x02.
- `cfg_mask`=0x01 pulsed during RD_CAP_W, then irq from edge_capture=0x04 only -> mask write 0x01 happens after the current event; the 0x04 pass returns to IDLE without `ev_valid`.
- Reset asserted in CLR -> next cycle all bus outputs are idle and `ev_valid`=0; INIT mask write reissued.
- PIO_EVT_TIMESTAMP_EN defined, irq at counter=100 -> `ev_ts`=102 (sampled in RD_CAP_W); build without the macro compiles with no `ev_ts` port.

Source files
------------

// File: rtl/pio_edge_servicer_pkg.sv
// Shared types and constants for the PIO edge servicer.
//   pio_evt_pkg: FSM state enum, PIO register addresses, default data width,
//   registered Avalon-MM command payload and a small constructor for it.
package pio_evt_pkg;

  localparam int unsigned PIO_WIDTH  = 6;
  localparam int unsigned AVM_ADDR_W = 2;
  localparam int unsigned AVM_DATA_W = 32;

  localparam logic [AVM_ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [AVM_ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [AVM_ADDR_W-1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_CAP,
    ST_RD_CAP_W,
    ST_CLR,
    ST_RD_LVL,
    ST_RD_LVL_W,
    ST_EMIT
  } state_t;

  // One cycle of Avalon-MM command as presented to the PIO slave.
  typedef struct packed {
    logic                  chipselect;
    logic                  write_n;
    logic [AVM_ADDR_W-1:0] address;
    logic [AVM_DATA_W-1:0] writedata;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_IDLE = '{
    chipselect: 1'b0,
    write_n:    1'b1,
    address:    ADDR_DATA,
    writedata:  '0
  };

  // Build an active (chip-selected) bus command.
  function automatic bus_cmd_t bus_cmd(input logic                  wr,
                                       input logic [AVM_ADDR_W-1:0] addr,
                                       input logic [AVM_DATA_W-1:0] data);
    bus_cmd_t c;
    c.chipselect = 1'b1;
    c.write_n    = ~wr;
    c.address    = addr;
    c.writedata  = data;
    return c;
  endfunction

endpackage

// File: rtl/pio_edge_servicer_if.sv
// Interfaces of the PIO edge servicer.
//   pio_avm_if: Avalon-MM link to the PIO s1 slave plus its irq line.
//     master: address/chipselect/write_n/writedata out, readdata/pio_irq in.
//   pio_ev_if: valid/ready event stream toward fabric logic.
//     master: ev_valid/ev_edges/ev_level (and ev_ts) out, ev_ready in.
//   ev_ts exists only when PIO_EVT_TIMESTAMP_EN is defined.
interface pio_avm_if;
  import pio_evt_pkg::*;

  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_chipselect;
  logic                  avm_write_n;
  logic [AVM_DATA_W-1:0] avm_writedata;
  logic [AVM_DATA_W-1:0] avm_readdata;
  logic                  pio_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, pio_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, pio_irq
  );
endinterface

interface pio_ev_if #(
  parameter int unsigned WIDTH = pio_evt_pkg::PIO_WIDTH,
  parameter int unsigned TS_W  = 32
);
  logic             ev_valid;
  logic             ev_ready;
  logic [WIDTH-1:0] ev_edges;
  logic [WIDTH-1:0] ev_level;

`ifdef PIO_EVT_TIMESTAMP_EN
  logic [TS_W-1:0]  ev_ts;

  modport master (
    output ev_valid, ev_edges, ev_level, ev_ts,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_edges, ev_level, ev_ts,
    output ev_ready
  );
`else
  localparam int unsigned unused_ts_w = TS_W;

  modport master (
    output ev_valid, ev_edges, ev_level,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_edges, ev_level,
    output ev_ready
  );
`endif
endinterface

// File: rtl/pio_edge_servicer_timestamp.sv
// pio_evt_timestamp: free-running wrap-around counter with a capture register.
//   clk, reset : clock, synchronous active-high reset
//   capture    : load the current count into ts
//   ts         : last captured count (held until the next capture)
// Only instantiated when PIO_EVT_TIMESTAMP_EN is defined.
module pio_evt_timestamp #(
  parameter int unsigned TS_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  output logic [TS_W-1:0] ts
);

  logic [TS_W-1:0] cnt_q;

  // Counter and capture register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ts    <= '0;
    end else begin
      cnt_q <= cnt_q + TS_W'(1);
      if (capture) begin
        ts <= cnt_q;
      end
    end
  end

endmodule

// File: rtl/pio_edge_servicer.sv
// pio_edge_servicer: hardware service loop for a 6-bit edge-capture PIO.
// Programs the PIO irq mask, waits for pio_irq, reads then clears the
// edge-capture register, reads the input levels and emits one event per
// non-empty batch on a valid/ready stream.
//   clk, reset   : clock, synchronous active-high reset
//   avm          : pio_avm_if.master, Avalon-MM link to PIO s1 (+ pio_irq)
//   cfg_mask     : new irq mask value
//   cfg_mask_wr  : one-cycle request to reprogram the mask
//   ev           : pio_ev_if.master, event stream (ev_edges, ev_level[, ev_ts])
//   busy         : high whenever the FSM is not idle
// Optional: define PIO_EVT_TIMESTAMP_EN to add the ev_ts timestamp output.
module pio_edge_servicer
  import pio_evt_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIO_WIDTH,
  parameter logic [WIDTH-1:0] MASK_INIT = WIDTH'(6'h3F),
  parameter int unsigned      TS_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  pio_avm_if.master        avm,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_wr,
  pio_ev_if.master         ev,
  output logic             busy
);

  state_t           state_q, state_d;
  bus_cmd_t         bus_q, bus_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q;
  logic [WIDTH-1:0] pend_val_q;
  logic             pend_clr_c;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] level_q;
  logic             ev_valid_q;
  logic             busy_q;
  logic             unused_rdata;

  assign unused_rdata = ^avm.avm_readdata[AVM_DATA_W-1:WIDTH];

  // Next-state logic; bus command decoded from the next state so the
  // registered bus lines up with the state being entered.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    pend_clr_c = 1'b0;
    bus_d      = BUS_IDLE;

    unique case (state_q)
      // Hold INIT until the mask write has actually been on the bus; after
      // reset the bus register starts idle, so this adds the one write cycle.
      ST_INIT: begin
        if (bus_q.chipselect && !bus_q.write_n) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_q || cfg_mask_wr) begin
          shadow_d   = cfg_mask_wr ? cfg_mask : pend_val_q;
          pend_clr_c = 1'b1;
          state_d    = ST_INIT;
        end else if (avm.pio_irq) begin
          state_d = ST_RD_CAP;
        end
      end
      ST_RD_CAP:   state_d = ST_RD_CAP_W;
      ST_RD_CAP_W: state_d = ST_CLR;
      ST_CLR:      state_d = ST_RD_LVL;
      ST_RD_LVL:   state_d = ST_RD_LVL_W;
      // An empty masked capture (spurious irq or mask change) emits nothing.
      ST_RD_LVL_W: state_d = (edge_q == '0) ? ST_IDLE : ST_EMIT;
      ST_EMIT: begin
        if (ev.ev_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:     state_d = ST_INIT;
    endcase

    unique case (state_d)
      ST_INIT:     bus_d = bus_cmd(1'b1, ADDR_MASK, AVM_DATA_W'(shadow_d));
      ST_RD_CAP,
      ST_RD_CAP_W: bus_d = bus_cmd(1'b0, ADDR_EDGE, '0);
      // Any write to edge_capture clears every capture bit in the PIO.
      ST_CLR:      bus_d = bus_cmd(1'b1, ADDR_EDGE, '1);
      ST_RD_LVL,
      ST_RD_LVL_W: bus_d = bus_cmd(1'b0, ADDR_DATA, '0);
      default:     bus_d = BUS_IDLE;
    endcase
  end

  // State, bus and event registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      bus_q      <= BUS_IDLE;
      shadow_q   <= MASK_INIT;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      edge_q     <= '0;
      level_q    <= '0;
      ev_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      shadow_q   <= shadow_d;
      ev_valid_q <= (state_d == ST_EMIT);
      busy_q     <= (state_d != ST_IDLE);

      // readdata is one cycle behind the address: sample in the *_W states.
      if (state_q == ST_RD_CAP_W) begin
        edge_q <= avm.avm_readdata[WIDTH-1:0] & shadow_q;
      end
      if (state_q == ST_RD_LVL_W) begin
        level_q <= avm.avm_readdata[WIDTH-1:0];
      end

      // Requests outside IDLE are parked; the latest value wins.
      if (cfg_mask_wr && (state_q != ST_IDLE)) begin
        pend_q     <= 1'b1;
        pend_val_q <= cfg_mask;
      end else if (pend_clr_c) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign avm.avm_chipselect = bus_q.chipselect;
  assign avm.avm_write_n    = bus_q.write_n;
  assign avm.avm_address    = bus_q.address;
  assign avm.avm_writedata  = bus_q.writedata;

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_edges = edge_q;
  assign ev.ev_level = level_q;
  assign busy        = busy_q;

`ifdef PIO_EVT_TIMESTAMP_EN
  logic ts_capture_c;

  assign ts_capture_c = (state_q == ST_RD_CAP_W);

  pio_evt_timestamp #(
    .TS_W (TS_W)
  ) u_ts (
    .clk     (clk),
    .reset   (reset),
    .capture (ts_capture_c),
    .ts      (ev.ev_ts)
  );
`else
  localparam int unsigned unused_ts_w = TS_W;
`endif

endmodule

// File: tb/tb_pio_edge_servicer.sv
// Self-checking bench for pio_edge_servicer: behavioural PIO slave model,
// per-cycle event checker, directed scenarios and a randomized soak.
module tb_pio_edge_servicer;
  import pio_evt_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] cfg_mask = 6'h3F;
  logic       cfg_mask_wr = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  pio_avm_if avm_if ();
  pio_ev_if #(.WIDTH(6), .TS_W(32)) ev_if ();

  pio_edge_servicer dut (
    .clk         (clk),
    .reset       (reset),
    .avm         (avm_if),
    .cfg_mask    (cfg_mask),
    .cfg_mask_wr (cfg_mask_wr),
    .ev          (ev_if),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural PIO slave ----------------
  logic [5:0]  pio_ec = '0, pio_mask = '0, level = '0, inj = '0;
  logic        irq_force = 1'b0;
  logic [31:0] rdata = '0;
  logic        prev_rd3 = 1'b0, prev_rd0 = 1'b0;
  logic [5:0]  cap_seen = '0, cap_mask = '0, lvl_seen = '0;
  int          cap_cnt = 0;
  logic [31:0] tb_cnt = '0;
  logic        rd_now, wr_now;

  assign rd_now = avm_if.avm_chipselect && avm_if.avm_write_n;
  assign wr_now = avm_if.avm_chipselect && !avm_if.avm_write_n;
  assign avm_if.avm_readdata = rdata;
  assign avm_if.pio_irq = (|(pio_ec & pio_mask)) | irq_force;

  always @(posedge clk) begin
    tb_cnt <= reset ? 32'd0 : tb_cnt + 32'd1;
    if (rd_now) begin
      case (avm_if.avm_address)
        2'd0:    rdata <= {26'd0, level};
        2'd2:    rdata <= {26'd0, pio_mask};
        2'd3:    rdata <= {26'd0, pio_ec};
        default: rdata <= '0;
      endcase
    end
    if (wr_now && avm_if.avm_address == 2'd2) pio_mask <= avm_if.avm_writedata[5:0];
    pio_ec <= ((wr_now && avm_if.avm_address == 2'd3) ? 6'd0 : pio_ec) | inj;
    // The initiator samples readdata on the second consecutive read cycle.
    if (!reset && rd_now && avm_if.avm_address == 2'd3 && prev_rd3) begin
      cap_seen <= rdata[5:0];
      cap_mask <= pio_mask;
      cap_cnt  <= cap_cnt + 1;
    end
    if (!reset && rd_now && avm_if.avm_address == 2'd0 && prev_rd0) lvl_seen <= rdata[5:0];
    prev_rd3 <= !reset && rd_now && avm_if.avm_address == 2'd3;
    prev_rd0 <= !reset && rd_now && avm_if.avm_address == 2'd0;
  end

  // ---------------- per-cycle event checker ----------------
  int         due = 0;
  int         seen_cap = 0;
  logic       pv = 1'b0, pr = 1'b0, fire;
  logic [5:0] pe = '0, pl = '0;

  always @(negedge clk) begin
    fire = 1'b0;
    if (reset) begin
      due      = 0;
      seen_cap = cap_cnt;
      pv       = 1'b0;
      pr       = 1'b0;
    end else begin
      // A capture must turn into ev_valid exactly 3 cycles later iff non-empty.
      if (due > 0) begin
        due--;
        if (due == 0) begin
          fire = 1'b1;
          check("ev_after_capture", 64'(ev_if.ev_valid), 64'((cap_seen & cap_mask) != 6'd0));
        end
      end
      if (cap_cnt != seen_cap) begin
        seen_cap = cap_cnt;
        due      = 3;
      end
      if (ev_if.ev_valid && !pv && !fire) check("ev_valid_unexpected_rise", 64'd1, 64'd0);
      if (pv && !pr) begin
        check("stall_valid_held", 64'(ev_if.ev_valid), 64'd1);
        check("stall_edges_held", 64'(ev_if.ev_edges), 64'(pe));
        check("stall_level_held", 64'(ev_if.ev_level), 64'(pl));
      end
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        check("accept_edges", 64'(ev_if.ev_edges), 64'(cap_seen & cap_mask));
        check("accept_level", 64'(ev_if.ev_level), 64'(lvl_seen));
      end
      if (rd_now) check("bus_read_addr_legal",
                        64'(avm_if.avm_address == 2'd0 || avm_if.avm_address == 2'd3), 64'd1);
      if (wr_now) begin
        check("bus_write_addr_legal",
              64'(avm_if.avm_address == 2'd2 || avm_if.avm_address == 2'd3), 64'd1);
        if (avm_if.avm_address == 2'd3)
          check("bus_clear_data", 64'(avm_if.avm_writedata), 64'hFFFF_FFFF);
      end
      pv = ev_if.ev_valid;
      pr = ev_if.ev_ready;
      pe = ev_if.ev_edges;
      pl = ev_if.ev_level;
    end
  end

  // ---------------- directed + random stimulus ----------------
  int e_cs [6] = '{1, 1, 1, 1, 1, 0};
  int e_wn [6] = '{1, 1, 0, 1, 1, 1};
  int e_ad [6] = '{3, 3, 3, 0, 0, 0};
  int e_v  [6] = '{0, 0, 0, 0, 0, 1};

  task automatic wait_valid(input string nm, input int max);
    int n = 0;
    while (!ev_if.ev_valid && n < max) begin
      tick;
      n++;
    end
    check(nm, 64'(ev_if.ev_valid), 64'd1);
  endtask

  task automatic accept;
    ev_if.ev_ready = 1'b1;
    tick;
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick;
      n++;
    end
    check(nm, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [31:0] wd;
    bit saw;
    int n;

    ev_if.ev_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick;

    // Reset state
    check("rst_cs",     64'(avm_if.avm_chipselect), 64'd0);
    check("rst_write_n", 64'(avm_if.avm_write_n),   64'd1);
    check("rst_addr",   64'(avm_if.avm_address),    64'd0);
    check("rst_wdata",  64'(avm_if.avm_writedata),  64'd0);
    check("rst_valid",  64'(ev_if.ev_valid),        64'd0);
    check("rst_edges",  64'(ev_if.ev_edges),        64'd0);
    check("rst_level",  64'(ev_if.ev_level),        64'd0);
    check("rst_busy",   64'(busy),                  64'd1);

    // Initial mask write, then idle
    reset = 1'b0;
    tick;
    check("init_cs",    64'(avm_if.avm_chipselect), 64'd1);
    check("init_wr",    64'(avm_if.avm_write_n),    64'd0);
    check("init_addr",  64'(avm_if.avm_address),    64'd2);
    check("init_data",  64'(avm_if.avm_writedata),  64'h3F);
    tick;
    check("init_busy_fall", 64'(busy), 64'd0);
    check("init_bus_idle",  64'(avm_if.avm_chipselect), 64'd0);
    check("init_pio_mask",  64'(pio_mask), 64'h3F);

    // First service pass: edges 0x05, level 0x04, 6 cycles irq -> ev_valid
    level = 6'h04;
    inj = 6'h05;
    tick;
    inj = 6'h00;
    for (int i = 0; i < 6; i++) begin
      tick;
      check($sformatf("pass1_cs_%0d", i + 1), 64'(avm_if.avm_chipselect), 64'(e_cs[i]));
      if (e_cs[i] != 0) begin
        check($sformatf("pass1_wn_%0d", i + 1), 64'(avm_if.avm_write_n), 64'(e_wn[i]));
        check($sformatf("pass1_addr_%0d", i + 1), 64'(avm_if.avm_address), 64'(e_ad[i]));
      end
      check($sformatf("pass1_valid_%0d", i + 1), 64'(ev_if.ev_valid), 64'(e_v[i]));
    end
    check("pass1_edges", 64'(ev_if.ev_edges), 64'h05);
    check("pass1_level", 64'(ev_if.ev_level), 64'h04);

    // Back-pressure: bit 1 toggles while stalled; coalesces into event 2
    for (int i = 0; i < 20; i++) begin
      inj = (i % 5 == 0) ? 6'h02 : 6'h00;
      tick;
    end
    inj = 6'h00;
    check("bp_still_valid", 64'(ev_if.ev_valid), 64'd1);
    check("bp_edges_kept",  64'(ev_if.ev_edges), 64'h05);
    accept;
    check("bp_dropped_valid", 64'(ev_if.ev_valid), 64'd0);
    wait_valid("bp_second_event", 12);
    check("bp_second_edges", 64'(ev_if.ev_edges), 64'h02);
    accept;
    wait_idle("bp_idle", 12);

    // Mask change requested mid-pass is applied after the event
    inj = 6'h08;
    tick;
    inj = 6'h00;
    tick;
    tick;
    cfg_mask = 6'h01;
    cfg_mask_wr = 1'b1;
    tick;
    cfg_mask_wr = 1'b0;
    wait_valid("mask_event", 10);
    check("mask_event_edges", 64'(ev_if.ev_edges), 64'h08);
    accept;
    found = 1'b0;
    wd = '0;
    n = 0;
    while (!found && n < 6) begin
      tick;
      n++;
      if (wr_now && avm_if.avm_address == 2'd2) begin
        found = 1'b1;
        wd = avm_if.avm_writedata;
      end
    end
    check("mask_write_seen", 64'(found), 64'd1);
    check("mask_write_data", 64'(wd), 64'h01);
    wait_idle("mask_idle", 6);
    inj = 6'h04;
    tick;
    inj = 6'h00;
    irq_force = 1'b1;
    tick;
    irq_force = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (ev_if.ev_valid) saw = 1'b1;
    end
    check("masked_pass_no_event", 64'(saw), 64'd0);
    check("masked_pass_idle", 64'(busy), 64'd0);
    check("masked_pass_cleared", 64'(pio_ec), 64'd0);
    cfg_mask = 6'h3F;
    cfg_mask_wr = 1'b1;
    tick;
    cfg_mask_wr = 1'b0;
    wait_idle("mask_restore_idle", 6);
    check("mask_restored", 64'(pio_mask), 64'h3F);

    // Reset in CLR aborts and re-issues the init write
    inj = 6'h01;
    tick;
    inj = 6'h00;
    repeat (3) tick;
    check("abort_in_clr", 64'(wr_now && avm_if.avm_address == 2'd3), 64'd1);
    reset = 1'b1;
    tick;
    check("abort_cs",    64'(avm_if.avm_chipselect), 64'd0);
    check("abort_wn",    64'(avm_if.avm_write_n),    64'd1);
    check("abort_addr",  64'(avm_if.avm_address),    64'd0);
    check("abort_wdata", 64'(avm_if.avm_writedata),  64'd0);
    check("abort_valid", 64'(ev_if.ev_valid),        64'd0);
    check("abort_busy",  64'(busy),                  64'd1);
    reset = 1'b0;
    tick;
    check("reinit_write", 64'(wr_now && avm_if.avm_address == 2'd2), 64'd1);
    check("reinit_data",  64'(avm_if.avm_writedata), 64'h3F);
    wait_idle("reinit_idle", 4);

`ifdef PIO_EVT_TIMESTAMP_EN
    // Timestamp: irq visible while counter == 100 -> ev_ts == 102
    n = 0;
    while (tb_cnt != 32'd99 && n < 300) begin
      tick;
      n++;
    end
    check("ts_align", 64'(tb_cnt), 64'd99);
    inj = 6'h10;
    tick;
    inj = 6'h00;
    wait_valid("ts_event", 10);
    check("ts_value", 64'(ev_if.ev_ts), 64'd102);
    accept;
    wait_idle("ts_idle", 12);
`endif

    // Randomized soak
    for (int c = 0; c < 3000; c++) begin
      inj = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
      if ($urandom_range(0, 15) == 0) level = 6'($urandom);
      ev_if.ev_ready = ($urandom_range(0, 9) < 7);
      cfg_mask = 6'h3F;
      cfg_mask_wr = ($urandom_range(0, 99) == 0);
      tick;
    end
    inj = 6'h00;
    cfg_mask_wr = 1'b0;
    ev_if.ev_ready = 1'b1;
    n = 0;
    while ((busy || avm_if.pio_irq || ev_if.ev_valid) && n < 100) begin
      tick;
      n++;
    end
    check("drain_idle", 64'(busy || avm_if.pio_irq || ev_if.ev_valid), 64'd0);
    check("drain_ec_empty", 64'(pio_ec), 64'd0);
    check("drain_mask", 64'(pio_mask), 64'h3F);
    ev_if.ev_ready = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
